// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage MIPS core. It also carries the
// 64-bit accumulator and step count that EX loops back during MADD/MSUB.
module ex_mem_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int STALL_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_whilo;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic [ALUOP_W-1:0]    r_aluop;
    logic [DATA_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_reg2;
    logic [2*DATA_W-1:0]   r_hilo;
    logic [1:0]            r_cnt;

    // Only the EX (bit 3) and MEM (bit 4) stall bits matter to this stage.
    logic w_ex_stall;
    logic w_mem_stall;
    logic w_unused_stall;

    assign w_ex_stall     = stall[3];
    assign w_mem_stall    = stall[4];
    assign w_unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values; the reset is synchronous, hence inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wd       <= '0;
            r_wreg     <= 1'b0;
            r_wdata    <= '0;
            r_whilo    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_aluop    <= '0;
            r_mem_addr <= '0;
            r_reg2     <= '0;
            r_hilo     <= '0;
            r_cnt      <= '0;
        end else if (!w_mem_stall) begin
            if (w_ex_stall) begin
                // Bubble to MEM, but keep the partial accumulation for EX.
                r_wd       <= '0;
                r_wreg     <= 1'b0;
                r_wdata    <= '0;
                r_whilo    <= 1'b0;
                r_hi       <= '0;
                r_lo       <= '0;
                r_aluop    <= '0;
                r_mem_addr <= '0;
                r_reg2     <= '0;
                r_hilo     <= hilo_i;
                r_cnt      <= cnt_i;
            end else begin
                r_wd       <= ex_wd;
                r_wreg     <= ex_wreg;
                r_wdata    <= ex_wdata;
                r_whilo    <= ex_whilo;
                r_hi       <= ex_hi;
                r_lo       <= ex_lo;
                r_aluop    <= ex_aluop;
                r_mem_addr <= ex_mem_addr;
                r_reg2     <= ex_reg2;
                r_hilo     <= '0;
                r_cnt      <= '0;
            end
        end
    end

    assign mem_wd       = r_wd;
    assign mem_wreg     = r_wreg;
    assign mem_wdata    = r_wdata;
    assign mem_whilo    = r_whilo;
    assign mem_hi       = r_hi;
    assign mem_lo       = r_lo;
    assign mem_aluop    = r_aluop;
    assign mem_mem_addr = r_mem_addr;
    assign mem_reg2     = r_reg2;
    assign hilo_o       = r_hilo;
    assign cnt_o        = r_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios followed by random
// traffic, compared against a behavioural model of the stage register.
module tb_ex_mem_reg;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } stage_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    stage_t     inp;
    stage_t     obs;
    stage_t     exp_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_wd        (inp.wd),
        .ex_wreg      (inp.wreg),
        .ex_wdata     (inp.wdata),
        .ex_whilo     (inp.whilo),
        .ex_hi        (inp.hi),
        .ex_lo        (inp.lo),
        .ex_aluop     (inp.aluop),
        .ex_mem_addr  (inp.addr),
        .ex_reg2      (inp.reg2),
        .hilo_i       (inp.hilo),
        .cnt_i        (inp.cnt),
        .mem_wd       (obs.wd),
        .mem_wreg     (obs.wreg),
        .mem_wdata    (obs.wdata),
        .mem_whilo    (obs.whilo),
        .mem_hi       (obs.hi),
        .mem_lo       (obs.lo),
        .mem_aluop    (obs.aluop),
        .mem_mem_addr (obs.addr),
        .mem_reg2     (obs.reg2),
        .hilo_o       (obs.hilo),
        .cnt_o        (obs.cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: what the stage should hold after one edge, given the
    // current controls and inputs.
    task automatic model_step();
        if (!rst || flush) begin
            exp_s = '0;
        end else if (stall[4]) begin
            exp_s = exp_s;
        end else if (stall[3]) begin
            exp_s      = '0;
            exp_s.hilo = inp.hilo;
            exp_s.cnt  = inp.cnt;
        end else begin
            exp_s      = inp;
            exp_s.hilo = '0;
            exp_s.cnt  = '0;
        end
    endtask

    task automatic compare_all();
        check("wd",    64'(obs.wd),    64'(exp_s.wd));
        check("wreg",  64'(obs.wreg),  64'(exp_s.wreg));
        check("wdata", 64'(obs.wdata), 64'(exp_s.wdata));
        check("whilo", 64'(obs.whilo), 64'(exp_s.whilo));
        check("hi",    64'(obs.hi),    64'(exp_s.hi));
        check("lo",    64'(obs.lo),    64'(exp_s.lo));
        check("aluop", 64'(obs.aluop), 64'(exp_s.aluop));
        check("addr",  64'(obs.addr),  64'(exp_s.addr));
        check("reg2",  64'(obs.reg2),  64'(exp_s.reg2));
        check("hilo",  obs.hilo,       exp_s.hilo);
        check("cnt",   64'(obs.cnt),   64'(exp_s.cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic rand_inputs();
        inp.wd    = 5'($urandom);
        inp.wreg  = 1'($urandom);
        inp.wdata = $urandom;
        inp.whilo = 1'($urandom);
        inp.hi    = $urandom;
        inp.lo    = $urandom;
        inp.aluop = 8'($urandom);
        inp.addr  = $urandom;
        inp.reg2  = $urandom;
        inp.hilo  = {$urandom, $urandom};
        inp.cnt   = 2'($urandom);
    endtask

    initial begin
        exp_s = '0;
        rst   = 1'b0;
        stall = '0;
        flush = 1'b0;
        inp   = '1;

        // Reset held for two edges with all inputs high.
        cycle();
        cycle();
        check("rst_all_zero", 64'(obs != '0), 64'd0);
        rst = 1'b1;
        cycle();
        check("rst_rel_wdata", 64'(obs.wdata), 64'hFFFF_FFFF);
        check("rst_rel_wd",    64'(obs.wd),    64'd31);

        // Plain advance.
        inp       = '0;
        inp.wd    = 5'd5;
        inp.wreg  = 1'b1;
        inp.wdata = 32'h1234_5678;
        inp.whilo = 1'b1;
        inp.hi    = 32'hA;
        inp.lo    = 32'hB;
        cycle();
        check("adv_wdata", 64'(obs.wdata), 64'h1234_5678);
        check("adv_hi_lo", {obs.hi, obs.lo}, {32'hA, 32'hB});
        check("adv_hilo",  obs.hilo, 64'd0);

        // MEM stall holds everything while inputs churn.
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle();
        end
        check("hold_wdata", 64'(obs.wdata), 64'h1234_5678);

        // EX stall: bubble with accumulator loopback, then advance.
        stall     = 6'b001111;
        inp.hilo  = 64'h0000_0001_0000_0002;
        inp.cnt   = 2'd1;
        inp.wreg  = 1'b1;
        inp.whilo = 1'b1;
        cycle();
        check("bub_wreg",  64'(obs.wreg),  64'd0);
        check("bub_whilo", 64'(obs.whilo), 64'd0);
        check("bub_aluop", 64'(obs.aluop), 64'd0);
        check("bub_hilo",  obs.hilo, 64'h0000_0001_0000_0002);
        check("bub_cnt",   64'(obs.cnt), 64'd1);
        stall     = '0;
        inp.wdata = 32'h55;
        cycle();
        check("madd_wdata", 64'(obs.wdata), 64'h55);
        check("madd_hilo",  obs.hilo, 64'd0);
        check("madd_cnt",   64'(obs.cnt), 64'd0);

        // Flush wins over a MEM stall holding a live accumulator.
        stall    = 6'b001000;
        inp.hilo = 64'hDEAD_BEEF_0000_0003;
        inp.cnt  = 2'd2;
        cycle();
        stall = 6'b011111;
        cycle();
        check("pre_flush_hilo", obs.hilo, 64'hDEAD_BEEF_0000_0003);
        flush = 1'b1;
        cycle();
        check("flush_all_zero", 64'(obs != '0), 64'd0);
        flush = 1'b0;

        // Reset while holding, then resume.
        stall = '0;
        rand_inputs();
        cycle();
        stall = 6'b011111;
        rst   = 1'b0;
        cycle();
        check("rst_hold_zero", 64'(obs != '0), 64'd0);
        rst   = 1'b1;
        stall = '0;
        rand_inputs();
        cycle();
        check("rst_resume_wdata", 64'(obs.wdata), 64'(inp.wdata));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            stall = 6'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 31) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
